// File: rtl/encoder_quad_decoder.sv
// rtl/encoder_quad_decoder.sv - quadrature front end: sync, glitch filter, 4x decode, position, velocity, errors
module encoder_quad_decoder #(
    parameter int POS_WIDTH  = 32,
    parameter int FILTER_LEN = 4,
    parameter int VEL_WINDOW = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 clear_pos,
    input  logic                 preset_valid,
    input  logic [POS_WIDTH-1:0] preset_value,
    input  logic                 err_clr,
    output logic [POS_WIDTH-1:0] position,
    output logic [POS_WIDTH-1:0] velocity,
    output logic                 vel_valid,
    output logic                 dir,
    output logic                 step_pulse,
    output logic [15:0]          err_count,
    output logic                 err_flag
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int PW = $clog2(FILTER_LEN + 4);
    localparam logic [FW-1:0] FLEN = FW'(FILTER_LEN);
    localparam logic [PW-1:0] PRIME_LAST = PW'(FILTER_LEN + 3);
    localparam logic [POS_WIDTH-1:0] WIN_LAST = POS_WIDTH'(VEL_WINDOW - 1);

    // Bit 1 is channel A, bit 0 is channel B throughout.
    logic [1:0]           sync1, sync2, filt, prev;
    logic [FW-1:0]        fcnt [2];
    logic [PW-1:0]        prime;
    logic                 enable;
    logic [1:0]           delta;
    logic                 fwd, rev, illegal;
    logic [POS_WIDTH-1:0] step_inc;
    logic [POS_WIDTH-1:0] win, acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
        end
    end

    // A channel only flips once the synchronised level has disagreed for FILTER_LEN straight cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt    <= 2'b00;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FLEN - 1'b1) begin
                    fcnt[i] <= '0;
                    filt[i] <= sync2[i];
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign enable = (prime == PRIME_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            prime <= '0;
            prev  <= 2'b00;
        end else begin
            if (!enable) prime <= prime + 1'b1;
            prev <= filt;
        end
    end

    // Position of a state around the forward cycle 00->10->11->01.
    function automatic logic [1:0] phase(input logic [1:0] ab);
        case (ab)
            2'b00:   phase = 2'd0;
            2'b10:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    always_comb begin
        delta    = phase(filt) - phase(prev);
        fwd      = enable && (delta == 2'd1);
        rev      = enable && (delta == 2'd3);
        illegal  = enable && (delta == 2'd2);
        step_inc = '0;
        if (fwd)      step_inc = POS_WIDTH'(1);
        else if (rev) step_inc = '1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            position   <= '0;
            velocity   <= '0;
            vel_valid  <= 1'b0;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            err_count  <= '0;
            err_flag   <= 1'b0;
            win        <= '0;
            acc        <= '0;
        end else begin
            if (clear_pos)         position <= '0;
            else if (preset_valid) position <= preset_value;
            else                   position <= position + step_inc;

            step_pulse <= fwd | rev;
            if (fwd | rev) dir <= fwd;

            if (err_clr) begin
                err_count <= {15'd0, illegal};
                err_flag  <= illegal;
            end else if (illegal) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                err_flag <= 1'b1;
            end

            // Free-running window; the terminal cycle's own step lands in the reported sample.
            if (win == WIN_LAST) begin
                win       <= '0;
                velocity  <= acc + step_inc;
                vel_valid <= 1'b1;
                acc       <= '0;
            end else begin
                win       <= win + 1'b1;
                acc       <= acc + step_inc;
                vel_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_encoder_quad_decoder.sv
// tb/tb_encoder_quad_decoder.sv - self-checking bench for encoder_quad_decoder
module tb_encoder_quad_decoder;
    localparam int PW   = 32;
    localparam int FL   = 4;
    localparam int VW   = 100;
    localparam int MAXE = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, enc_a, enc_b, clear_pos, preset_valid, err_clr;
    logic [PW-1:0] preset_value;
    logic [PW-1:0] position, velocity;
    logic          vel_valid, dir, step_pulse, err_flag;
    logic [15:0]   err_count;

    encoder_quad_decoder #(.POS_WIDTH(PW), .FILTER_LEN(FL), .VEL_WINDOW(VW)) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .clear_pos(clear_pos), .preset_valid(preset_valid), .preset_value(preset_value),
        .err_clr(err_clr), .position(position), .velocity(velocity), .vel_valid(vel_valid),
        .dir(dir), .step_pulse(step_pulse), .err_count(err_count), .err_flag(err_flag)
    );

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Reference model state, indexed by clock edges since reset released.
    int            m_e;
    logic [1:0]    rawh [MAXE];
    int            stepv [MAXE];
    logic [1:0]    m_filt, m_filt_old;
    logic [PW-1:0] m_pos, m_vel;
    logic          m_vv, m_dir, m_sp, m_errf;
    logic [15:0]   m_errc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 0 none, 1 forward, -1 reverse, 2 illegal
    function automatic int classify(input logic [1:0] p, input logic [1:0] c);
        logic [1:0] ring [4];
        int pi;
        ring[0] = 2'b00; ring[1] = 2'b10; ring[2] = 2'b11; ring[3] = 2'b01;
        pi = 0;
        for (int i = 0; i < 4; i++) if (ring[i] == p) pi = i;
        if (c == p) return 0;
        if (c == ring[(pi + 1) % 4]) return 1;
        if (c == ring[(pi + 3) % 4]) return -1;
        return 2;
    endfunction

    task automatic model_step();
        logic [1:0] nf;
        int st, c, s, idx;
        logic ill, flip, r;
        if (reset) begin
            m_e = 0; m_filt = 2'b00; m_filt_old = 2'b00;
            m_pos = '0; m_vel = '0; m_vv = 0; m_dir = 0; m_sp = 0; m_errc = '0; m_errf = 0;
        end else begin
            m_e++;
            if (m_e >= MAXE) $fatal(1, "FAIL model_range: edge index %0d beyond table", m_e);
            rawh[m_e] = {enc_a, enc_b};
            st = 0; ill = 0;
            if (m_e >= FL + 4) begin
                c = classify(m_filt_old, m_filt);
                if (c == 2) ill = 1; else st = c;
            end
            // Each filtered channel flips once the last FL synchronised samples all disagree with it.
            nf = m_filt;
            for (int ch = 0; ch < 2; ch++) begin
                flip = 1;
                for (int k = 2; k <= FL + 1; k++) begin
                    idx = m_e - k;
                    r = (idx >= 1) ? rawh[idx][ch] : 1'b0;
                    if (r == m_filt[ch]) flip = 0;
                end
                if (flip) nf[ch] = ~m_filt[ch];
            end
            m_filt_old = m_filt;
            m_filt = nf;
            stepv[m_e] = st;
            if (clear_pos)         m_pos = '0;
            else if (preset_valid) m_pos = preset_value;
            else                   m_pos = m_pos + PW'(st);
            m_sp = (st != 0);
            if (st != 0) m_dir = (st == 1);
            if (err_clr) begin
                m_errc = ill ? 16'd1 : 16'd0;
                m_errf = ill;
            end else if (ill) begin
                if (m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
                m_errf = 1;
            end
            if (m_e % VW == 0) begin
                s = 0;
                for (int k = m_e - VW + 1; k <= m_e; k++) s += stepv[k];
                m_vel = PW'(s);
                m_vv = 1;
            end else begin
                m_vv = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("cyc position", position, m_pos);
        chk("cyc velocity", velocity, m_vel);
        chk("cyc vel_valid", 32'(vel_valid), 32'(m_vv));
        chk("cyc dir", 32'(dir), 32'(m_dir));
        chk("cyc step_pulse", 32'(step_pulse), 32'(m_sp));
        chk("cyc err_count", 32'(err_count), 32'(m_errc));
        chk("cyc err_flag", 32'(err_flag), 32'(m_errf));
        if (step_pulse) pulses++;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic set_enc(input logic [1:0] v);
        {enc_a, enc_b} = v;
    endtask

    typedef struct {
        logic [1:0]  enc;
        logic [31:0] pos;
        logic        dirx;
        logic [15:0] errc;
    } vec_t;

    vec_t tbl [10];
    logic [1:0] fseq [4];
    logic [1:0] t5seq [13];

    initial begin
        tbl[0] = '{2'b01, 32'd1, 1'b1, 16'd0};
        tbl[1] = '{2'b00, 32'd2, 1'b1, 16'd0};
        tbl[2] = '{2'b10, 32'd3, 1'b1, 16'd0};
        tbl[3] = '{2'b11, 32'd4, 1'b1, 16'd0};
        tbl[4] = '{2'b10, 32'd3, 1'b0, 16'd0};
        tbl[5] = '{2'b00, 32'd2, 1'b0, 16'd0};
        tbl[6] = '{2'b11, 32'd2, 1'b0, 16'd1};
        tbl[7] = '{2'b01, 32'd3, 1'b1, 16'd1};
        tbl[8] = '{2'b10, 32'd3, 1'b1, 16'd2};
        tbl[9] = '{2'b11, 32'd4, 1'b1, 16'd2};
        fseq[0] = 2'b01; fseq[1] = 2'b00; fseq[2] = 2'b10; fseq[3] = 2'b11;
        t5seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11,
                  2'b10, 2'b00, 2'b01};

        reset = 1; set_enc(2'b11); clear_pos = 0; preset_valid = 0; preset_value = '0; err_clr = 0;

        // 1: static 11 through reset and priming
        hold(5);
        reset = 0;
        pulses = 0;
        hold(50);
        chk("t1 position", position, 32'd0);
        chk("t1 err_count", 32'(err_count), 32'd0);
        chk("t1 pulses", 32'(pulses), 32'd0);

        // Table: mixed forward, reverse and illegal moves from 11
        for (int i = 0; i < 10; i++) begin
            set_enc(tbl[i].enc);
            hold(10);
            chk("tbl position", position, tbl[i].pos);
            chk("tbl dir", 32'(dir), 32'(tbl[i].dirx));
            chk("tbl err_count", 32'(err_count), 32'(tbl[i].errc));
        end
        err_clr = 1; tick(); err_clr = 0;
        chk("errclr count", 32'(err_count), 32'd0);
        chk("errclr flag", 32'(err_flag), 32'd0);

        // 2: 32 forward transitions, then reverse through zero
        clear_pos = 1; tick(); clear_pos = 0;
        chk("t2 cleared", position, 32'd0);
        pulses = 0;
        for (int c = 0; c < 8; c++)
            for (int j = 0; j < 4; j++) begin
                set_enc(fseq[j]);
                hold(10);
            end
        chk("t2 position", position, 32'd32);
        chk("t2 dir", 32'(dir), 32'd1);
        chk("t2 pulses", 32'(pulses), 32'd32);
        clear_pos = 1; tick(); clear_pos = 0;
        set_enc(2'b10);
        hold(10);
        chk("t2 wrap", position, 32'hFFFFFFFF);
        chk("t2 dir rev", 32'(dir), 32'd0);

        // 3: short glitch rejected, sustained edge steps exactly 7 cycles later
        set_enc(2'b00);
        hold(10);
        pulses = 0;
        set_enc(2'b10); hold(3);
        set_enc(2'b00); hold(10);
        chk("t3 glitch pulses", 32'(pulses), 32'd0);
        chk("t3 glitch position", position, 32'hFFFFFFFE);
        set_enc(2'b10);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("t3 step timing", 32'(step_pulse), (k == 7) ? 32'd1 : 32'd0);
        end
        hold(5);
        chk("t3 position", position, 32'hFFFFFFFF);
        chk("t3 pulses", 32'(pulses), 32'd1);

        // 4: illegal jump, then err_clr coincident with another illegal decode
        set_enc(2'b00);
        hold(10);
        set_enc(2'b11);
        hold(10);
        chk("t4 err_count", 32'(err_count), 32'd1);
        chk("t4 err_flag", 32'(err_flag), 32'd1);
        chk("t4 position", position, 32'hFFFFFFFE);
        set_enc(2'b00);
        hold(6);
        err_clr = 1; tick(); err_clr = 0;
        chk("t4 clr+illegal count", 32'(err_count), 32'd1);
        chk("t4 clr+illegal flag", 32'(err_flag), 32'd1);
        chk("t4 no step", 32'(step_pulse), 32'd0);
        hold(5);
        chk("t4 position kept", position, 32'hFFFFFFFE);

        // 5: 10 forward + 3 reverse inside one window
        for (int k = 0; k < 100 && (m_e % VW) != 0; k++) tick();
        for (int j = 0; j < 13; j++) begin
            set_enc(t5seq[j]);
            hold(5);
        end
        for (int k = 0; k < 100; k++) begin
            tick();
            if (m_e % VW == 0) break;
        end
        chk("t5 vel_valid", 32'(vel_valid), 32'd1);
        chk("t5 velocity", velocity, 32'd7);
        tick();
        chk("t5 vel_valid drop", 32'(vel_valid), 32'd0);
        for (int k = 0; k < 100; k++) begin
            tick();
            if (m_e % VW == 0) break;
        end
        chk("t5 idle vel_valid", 32'(vel_valid), 32'd1);
        chk("t5 idle velocity", velocity, 32'd0);

        // 6: clear/preset against a coincident step
        set_enc(2'b00);
        hold(6);
        clear_pos = 1; preset_valid = 1; preset_value = 32'd1234;
        tick();
        clear_pos = 0; preset_valid = 0;
        chk("t6 clear wins", position, 32'd0);
        set_enc(2'b10);
        hold(6);
        preset_valid = 1;
        tick();
        preset_valid = 0;
        chk("t6 preset", position, 32'd1234);
        hold(5);
        chk("t6 preset held", position, 32'd1234);

        // Randomised traffic against the model, with a reset in the middle
        for (int seg = 0; seg < 300; seg++) begin
            if (seg == 150) begin
                reset = 1;
                hold(2);
                chk("mid reset position", position, 32'd0);
                chk("mid reset err_count", 32'(err_count), 32'd0);
                reset = 0;
            end
            set_enc(2'($urandom_range(0, 3)));
            for (int j = 0, h = $urandom_range(1, 12); j < h; j++) begin
                clear_pos    = ($urandom_range(0, 39) == 0);
                preset_valid = ($urandom_range(0, 39) == 0);
                preset_value = $urandom;
                err_clr      = ($urandom_range(0, 29) == 0);
                tick();
            end
            clear_pos = 0; preset_valid = 0; err_clr = 0;
        end
        hold(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
